// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display scheduler.
package disp_sched_pkg;

  // Scheduler states: no owner, owner granted, blanking gap before the next owner.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StHold  = 2'b01,
    StBlank = 2'b10
  } state_e;

  // Ownership modes as driven on the mode input.
  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_PRIO   = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  // Counter/index width for a count of n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_scheduler_rr_pick.sv
// Circular next-requester finder: searches start+1, start+2, ... wrapping round,
// with start itself examined last. With start = N_REQ-1 it yields the lowest
// requesting index, so it doubles as the fixed-priority picker.
module rr_pick
  import disp_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEL_W = cnt_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // First requester in circular order after start; offset N_REQ wraps back to start.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = start + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/disp_scheduler.sv
// Display ownership scheduler: picks one requester at a time to drive the
// seven-segment path, inserting a blanking gap whenever the owner changes.
module disp_scheduler
  import disp_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DWELL_CYC = 100_000_000,
  parameter int unsigned BLANK_CYC = 1_000_000,
  localparam int unsigned SEL_W    = cnt_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 RSTN,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [8*N_REQ-1:0]   req_point,
  input  logic [8*N_REQ-1:0]   req_le,
  input  logic [1:0]           mode,
  input  logic [SEL_W-1:0]     manual_sel,
  input  logic                 next_pulse,
  output logic [31:0]          disp_data,
  output logic [7:0]           disp_point,
  output logic [7:0]           disp_le,
  output logic [N_REQ-1:0]     grant,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 valid,
  output logic                 switch_pulse
);

  localparam int unsigned DwellW = cnt_width(DWELL_CYC);
  localparam int unsigned GapW   = cnt_width(BLANK_CYC);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYC - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'(BLANK_CYC - 1);
  localparam logic [SEL_W-1:0]  SelLast   = SEL_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              owned_q, owned_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [GapW-1:0]   gap_q, gap_d;

  logic [31:0]       data_q, data_d;
  logic [7:0]        point_q, point_d;
  logic [7:0]        le_q, le_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              switch_q, switch_d;

  logic [SEL_W-1:0]  auto_start;
  logic              auto_found, prio_found;
  logic [SEL_W-1:0]  auto_idx, prio_idx;
  logic              cand_found;
  logic [SEL_W-1:0]  cand_idx;
  logic              frozen;
  logic              any_req;

  // Until someone has owned the display, round-robin starts from index 0.
  assign auto_start = owned_q ? sel_q : SelLast;
  assign frozen     = (mode == MODE_FREEZE);
  assign any_req    = |req;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_auto_pick (
    .req   (req),
    .start (auto_start),
    .found (auto_found),
    .idx   (auto_idx)
  );

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_prio_pick (
    .req   (req),
    .start (SelLast),
    .found (prio_found),
    .idx   (prio_idx)
  );

  // Candidate owner for the current mode; freeze never offers one.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    case (mode)
      MODE_AUTO: begin
        cand_found = auto_found;
        cand_idx   = auto_idx;
      end
      MODE_MANUAL: begin
        cand_found = req[manual_sel];
        cand_idx   = manual_sel;
      end
      MODE_PRIO: begin
        cand_found = prio_found;
        cand_idx   = prio_idx;
      end
      default: begin
        cand_found = 1'b0;
        cand_idx   = '0;
      end
    endcase
  end

  // Ownership FSM and counters; freeze holds everything in place.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owned_d = owned_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    if (!frozen) begin
      unique case (state_q)
        StIdle: begin
          if (cand_found) begin
            state_d = StBlank;
            gap_d   = '0;
          end
        end
        StHold: begin
          if (!req[sel_q]) begin
            state_d = any_req ? StBlank : StIdle;
            gap_d   = '0;
          end else if (mode == MODE_AUTO) begin
            // Expiry and next_pulse together still make only one re-pick.
            if (dwell_q == DwellLast || next_pulse) begin
              if (cand_idx != sel_q) begin
                state_d = StBlank;
                gap_d   = '0;
              end else begin
                dwell_d = '0;
              end
            end else begin
              dwell_d = dwell_q + DwellW'(1);
            end
          end else if (!cand_found) begin
            state_d = StIdle;
          end else if (cand_idx != sel_q) begin
            state_d = StBlank;
            gap_d   = '0;
          end else if (dwell_q != DwellLast) begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end
        StBlank: begin
          if (gap_q == GapLast) begin
            if (cand_found) begin
              state_d = StHold;
              sel_d   = cand_idx;
              owned_d = 1'b1;
              dwell_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Next-cycle output values: the owner's inputs while holding, otherwise blank.
  always_comb begin
    data_d   = '0;
    point_d  = '0;
    le_d     = '0;
    grant_d  = '0;
    valid_d  = (state_d == StHold);
    switch_d = (state_q == StBlank) && (state_d == StHold);
    if (valid_d) begin
      grant_d = N_REQ'(1) << sel_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (sel_d == SEL_W'(i)) begin
          data_d  = req_data[32*i +: 32];
          point_d = req_point[8*i +: 8];
          le_d    = req_le[8*i +: 8];
        end
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      owned_q  <= 1'b0;
      dwell_q  <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      point_q  <= '0;
      le_q     <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      owned_q  <= owned_d;
      dwell_q  <= dwell_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      point_q  <= point_d;
      le_q     <= le_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
    end
  end

  assign disp_data    = data_q;
  assign disp_point   = point_q;
  assign disp_le      = le_q;
  assign grant        = grant_q;
  assign cur_sel      = sel_q;
  assign valid        = valid_q;
  assign switch_pulse = switch_q;

endmodule
